// File: rtl/aud_sched_pkg.sv
// Shared types and constants for the TDM audio scheduler.
// The optional hold-last fill is controlled by the macro AUD_SCHED_HOLD_LAST_EN (see aud_tdm_scheduler).
package aud_sched_pkg;

   localparam int AUD_TID_W  = 3;
   localparam int AUD_DATA_W = 32;

   localparam logic [AUD_DATA_W-1:0] FILL_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } aud_sched_state_e;

endpackage

// File: rtl/aud_ch_mux.sv
// NUM_CH-way selection of the current channel's data/valid and one-hot ready decode.
module aud_ch_mux
   import aud_sched_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH*AUD_DATA_W-1:0] ch_tdata_i,
   input  logic [NUM_CH-1:0]            ch_tvalid_i,
   input  logic [AUD_TID_W-1:0]         cur_ch_i,
   input  logic                         ready_en_i,
   output logic [AUD_DATA_W-1:0]        sel_tdata_o,
   output logic                         sel_tvalid_o,
   output logic [NUM_CH-1:0]            sel_oh_o,
   output logic [NUM_CH-1:0]            ch_tready_o
);

   always_comb begin
      sel_tdata_o  = FILL_ZERO;
      sel_tvalid_o = 1'b0;
      sel_oh_o     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cur_ch_i == AUD_TID_W'(c)) begin
            sel_tdata_o  = ch_tdata_i[c*AUD_DATA_W +: AUD_DATA_W];
            sel_tvalid_o = ch_tvalid_i[c];
            sel_oh_o[c]  = 1'b1;
         end
      end
      ch_tready_o = ready_en_i ? sel_oh_o : '0;
   end

endmodule

// File: rtl/aud_tdm_scheduler.sv
// Round-robin TDM scheduler: one tagged word per channel per frame, timeout fill on underrun.
// Define AUD_SCHED_HOLD_LAST_EN to fill underruns with the channel's last sample instead of zero.
module aud_tdm_scheduler
   import aud_sched_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int TIMEOUT   = 256,
   parameter int TIMEOUT_W = 9
) (
   input  logic                         s_axis_aud_aclk,
   input  logic                         s_axis_aud_aresetn,
   input  logic                         enable,
   input  logic [NUM_CH-1:0]            ch_mask,
   input  logic                         underrun_clr,
   input  logic [NUM_CH*AUD_DATA_W-1:0] s_ch_tdata,
   input  logic [NUM_CH-1:0]            s_ch_tvalid,
   output logic [NUM_CH-1:0]            s_ch_tready,
   output logic [AUD_DATA_W-1:0]        m_axis_aud_tdata,
   output logic [AUD_TID_W-1:0]         m_axis_aud_tid,
   output logic                         m_axis_aud_tvalid,
   input  logic                         m_axis_aud_tready,
   output logic [NUM_CH-1:0]            underrun_sticky,
   output logic [15:0]                  frame_cnt,
   output logic                         busy,
   output logic                         irq,
   output aud_sched_state_e             dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the master side holds tdata/tid stable while valid is high and ready is low.

   localparam logic [AUD_TID_W-1:0] LAST_CH = AUD_TID_W'(NUM_CH - 1);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

   aud_sched_state_e        state_q, state_d;
   logic [AUD_TID_W-1:0]    cur_ch_q, cur_ch_d;
   logic [TIMEOUT_W-1:0]    timer_q, timer_d;
   logic [AUD_DATA_W-1:0]   data_q, data_d;
   logic [NUM_CH-1:0]       sticky_q, sticky_d;
   logic [15:0]             frame_q, frame_d;
   logic                    mask_cur_q, mask_cur_d;

   logic                    ready_en;
   logic [AUD_DATA_W-1:0]   sel_tdata;
   logic                    sel_tvalid;
   logic [NUM_CH-1:0]       sel_oh;
   logic [AUD_DATA_W-1:0]   fill_ur;
   logic                    timeout_hit;
   logic                    wait_enter;
   logic                    mask_next;

   aud_ch_mux #(.NUM_CH(NUM_CH)) u_mux (
      .ch_tdata_i   (s_ch_tdata),
      .ch_tvalid_i  (s_ch_tvalid),
      .cur_ch_i     (cur_ch_q),
      .ready_en_i   (ready_en),
      .sel_tdata_o  (sel_tdata),
      .sel_tvalid_o (sel_tvalid),
      .sel_oh_o     (sel_oh),
      .ch_tready_o  (s_ch_tready)
   );

   assign timeout_hit = (timer_q == TO_LAST);

   always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
      if (!s_axis_aud_aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (enable) state_d = WAIT;
         WAIT: if (mask_cur_q || sel_tvalid || timeout_hit) state_d = SEND;
         SEND: if (m_axis_aud_tready) state_d = (cur_ch_q != LAST_CH || enable) ? WAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_en          = (state_q == WAIT) && !mask_cur_q;
      m_axis_aud_tvalid = (state_q == SEND);
      busy              = (state_q != IDLE);
      dbg_state         = state_q;
   end

   always_comb begin
      cur_ch_d = cur_ch_q;
      timer_d  = timer_q;
      data_d   = data_q;
      frame_d  = frame_q;
      sticky_d = underrun_clr ? '0 : sticky_q;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               cur_ch_d = '0;
               timer_d  = '0;
            end
         end
         WAIT: begin
            if (mask_cur_q) begin
               data_d = FILL_ZERO;
            end else if (sel_tvalid) begin
               data_d = sel_tdata;
            end else if (timeout_hit) begin
               data_d   = fill_ur;
               sticky_d = sticky_d | sel_oh;  // a new underrun beats a same-cycle clear
            end else begin
               timer_d = timer_q + TIMEOUT_W'(1);
            end
         end
         SEND: begin
            if (m_axis_aud_tready) begin
               timer_d = '0;
               if (cur_ch_q == LAST_CH) begin
                  cur_ch_d = '0;
                  frame_d  = frame_q + 16'd1;
               end else begin
                  cur_ch_d = cur_ch_q + AUD_TID_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // The mask bit is latched once per channel visit, as the scheduler enters WAIT.
   assign wait_enter = (state_d == WAIT) && (state_q != WAIT);

   always_comb begin
      mask_next = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cur_ch_d == AUD_TID_W'(c)) mask_next = ch_mask[c];
      end
      mask_cur_d = wait_enter ? mask_next : mask_cur_q;
   end

   always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
      if (!s_axis_aud_aresetn) begin
         cur_ch_q   <= '0;
         timer_q    <= '0;
         data_q     <= '0;
         sticky_q   <= '0;
         frame_q    <= '0;
         mask_cur_q <= 1'b0;
      end else begin
         cur_ch_q   <= cur_ch_d;
         timer_q    <= timer_d;
         data_q     <= data_d;
         sticky_q   <= sticky_d;
         frame_q    <= frame_d;
         mask_cur_q <= mask_cur_d;
      end
   end

`ifdef AUD_SCHED_HOLD_LAST_EN
   logic [AUD_DATA_W-1:0] last_q [NUM_CH];

   always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
      if (!s_axis_aud_aresetn) begin
         for (int c = 0; c < NUM_CH; c++) last_q[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ready_en && sel_tvalid && sel_oh[c]) last_q[c] <= sel_tdata;
         end
      end
   end

   always_comb begin
      fill_ur = FILL_ZERO;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_oh[c]) fill_ur = last_q[c];
      end
   end
`else
   assign fill_ur = FILL_ZERO;
`endif

   assign m_axis_aud_tdata = data_q;
   assign m_axis_aud_tid   = cur_ch_q;
   assign underrun_sticky  = sticky_q;
   assign frame_cnt        = frame_q;
   assign irq              = |sticky_q;

endmodule
